regfile_sb: RTL and testbench

Parametrised general-purpose register file for the pipelined MIPS core: N combinational read ports, one write port, and an integrated scoreboard of pending-write bits for interlock detection in decode. Writes commit on the rising clock edge. Optional write-through bypass lets a read see same-cycle write data. Sits between the decode stage (reads, reservations) and the write-back stage (writes).

---
 rtl/regfile_sb.sv | 151 +++++++++++++++
 tb/tb_regfile_sb.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : General-purpose register file for the pipelined MIPS core,
//               with an integrated scoreboard of pending-write bits used by
//               decode for interlock detection.
//
//   Parameters
//     DATA_W   register width in bits
//     ADDR_W   address width; depth = 2**ADDR_W
//     NUM_RD   number of combinational read ports (1..4)
//
//   Ports
//     clk       clock; all state updates on the rising edge
//     rst_n     asynchronous active-low reset (clears regs, flags, count)
//     rd_addr   read addresses, port i at [i*ADDR_W +: ADDR_W]
//     rd_data   read data, port i at [i*DATA_W +: DATA_W]
//     rd_busy   port i register has an outstanding, unsatisfied reservation
//     wr_en     write-back strobe
//     wr_addr   write-back destination
//     wr_data   write-back value
//     rsv_en    decode reserves rsv_addr for a future write
//     rsv_addr  destination being reserved
//     pend_cnt  registered popcount of the pending flags
//
//   Build option
//     REGFILE_BYPASS_EN  when defined, a read whose address matches the
//                        active write returns wr_data in the same cycle and
//                        its rd_busy is suppressed.
//
// Revision    : 1.0  initial release
// ============================================================================

module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int C_DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]  r_regs [C_DEPTH];
  logic [C_DEPTH-1:0] r_pend;
  logic [C_DEPTH-1:0] w_pend_nxt;
  logic [ADDR_W:0]    r_cnt;

  logic w_wr_act;
  logic w_rsv_act;
  logic w_inc;
  logic w_dec;

  // Address 0 is hardwired: strobes aimed at it are simply dropped.
  assign w_wr_act  = wr_en  && (wr_addr  != '0);
  assign w_rsv_act = rsv_en && (rsv_addr != '0);

  // --------------------------------------------------------------------------
  // Storage. Entry 0 is never written, so it stays at its reset value of 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < C_DEPTH; k++) begin
        r_regs[k] <= '0;
      end
    end else if (w_wr_act) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard. The reservation is applied after the write-back clear so that
  // a same-address collision leaves the flag set: the newly issued producer
  // supersedes the one retiring this cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_act) begin
      w_pend_nxt[wr_addr] = 1'b0;
    end
    if (w_rsv_act) begin
      w_pend_nxt[rsv_addr] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  // Count deltas derived from the flag transitions rather than a full
  // popcount: +1 when a clear flag gets reserved, -1 when a set flag is
  // retired by a write that is not simultaneously re-reserved.
  assign w_inc = w_rsv_act && !r_pend[rsv_addr];
  assign w_dec = w_wr_act && r_pend[wr_addr] &&
                 !(w_rsv_act && (rsv_addr == wr_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign pend_cnt = r_cnt;

  // --------------------------------------------------------------------------
  // Read ports, fully independent of one another.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic              w_hit;

    assign w_a = rd_addr[i*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
    // Forward the value being written this cycle; the reservation it
    // satisfies no longer needs to stall the reader.
    assign w_hit = w_wr_act && (wr_addr == w_a);
`else
    assign w_hit = 1'b0;
`endif

    assign rd_data[i*DATA_W +: DATA_W] = (w_a == '0) ? '0      :
                                         w_hit      ? wr_data :
                                                      r_regs[w_a];
    assign rd_busy[i] = r_pend[w_a] && !w_hit;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Self-checking bench for regfile_sb. A behavioural model holds
//               register values and pending flags as plain arrays; the
//               pending count is a popcount of the model flags.
// Revision    : 1.0  initial release
// ============================================================================

module tb_regfile_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 2**AW;

  logic              clk;
  logic              rst_n;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic [AW:0]       pend_cnt;

  logic [DW-1:0] mref [DEPTH];
  bit            pref [DEPTH];
  int            total;
  int            bad;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .pend_cnt (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return mref[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return 1'b0;
`endif
    return pref[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int k = 0; k < DEPTH; k++) n += pref[k] ? 1 : 0;
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      mref[k] = '0;
      pref[k] = 1'b0;
    end
  endtask

  // Advance one clock, applying the held strobes to the model; returns at
  // the following falling edge where new stimulus is applied.
  task automatic step();
    @(posedge clk);
    if (wr_en && wr_addr != 0) begin
      mref[wr_addr] = wr_data;
      pref[wr_addr] = 1'b0;
    end
    if (rsv_en && rsv_addr != 0) pref[rsv_addr] = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [AW-1:0] a;
    // reset state at time zero
    total++;
    if (pend_cnt !== '0 || rd_busy !== '0) begin
      bad++;
      $display("FAIL reset_init pend_cnt=%0d busy=%b want 0/00", pend_cnt, rd_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      wr_en = 1'b1; wr_addr = AW'($urandom); wr_data = $urandom;
      rsv_en = 1'b1; rsv_addr = AW'($urandom);
      step();
    end
    idle();
    #2 rst_n = 1'b0;
    #1;
    for (int p = 0; p < NR; p++) begin
      a = AW'($urandom_range(1, DEPTH-1));
      set_rd(p, a);
    end
    #1;
    for (int p = 0; p < NR; p++) begin
      total++;
      if (rd_data[p*DW +: DW] !== '0 || rd_busy[p] !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold port%0d data=%h busy=%b want 0/0",
                 p, rd_data[p*DW +: DW], rd_busy[p]);
      end
    end
    total++;
    if (pend_cnt !== '0) begin
      bad++;
      $display("FAIL reset_hold_cnt pend_cnt=%0d want 0", pend_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      set_rd(0, AW'(r));
      set_rd(1, AW'(DEPTH-1-r));
      #1;
      for (int p = 0; p < NR; p++) begin
        total++;
        if (rd_data[p*DW +: DW] !== '0 || rd_busy[p] !== 1'b0) begin
          bad++;
          $display("FAIL reset_sweep port%0d addr=%0d data=%h busy=%b want 0/0",
                   p, rd_addr[p*AW +: AW], rd_data[p*DW +: DW], rd_busy[p]);
        end
      end
      step();
    end
  endtask

  task automatic test_basic();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    step();
    idle();
    set_rd(0, 5'd5); set_rd(1, 5'd5);
    #1;
    for (int p = 0; p < NR; p++) begin
      total++;
      if (rd_data[p*DW +: DW] !== 32'hDEADBEEF) begin
        bad++;
        $display("FAIL basic_r5 port%0d got=%h want=deadbeef", p, rd_data[p*DW +: DW]);
      end
    end
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    step();
    idle();
    set_rd(0, 5'd0); set_rd(1, 5'd0);
    #1;
    for (int p = 0; p < NR; p++) begin
      total++;
      if (rd_data[p*DW +: DW] !== '0) begin
        bad++;
        $display("FAIL basic_r0 port%0d got=%h want=0", p, rd_data[p*DW +: DW]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] old_v;
    old_v = $urandom;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = old_v;
    step();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    set_rd(0, 5'd7); set_rd(1, 5'd5);
    #1;
    total++;
`ifdef REGFILE_BYPASS_EN
    if (rd_data[0 +: DW] !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL bypass_same got=%h want=a5a5a5a5", rd_data[0 +: DW]);
    end
`else
    if (rd_data[0 +: DW] !== old_v) begin
      bad++;
      $display("FAIL bypass_same got=%h want=%h", rd_data[0 +: DW], old_v);
    end
`endif
    total++;
    if (rd_data[DW +: DW] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL bypass_other got=%h want=deadbeef", rd_data[DW +: DW]);
    end
    step();
    idle();
    #1;
    total++;
    if (rd_data[0 +: DW] !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL bypass_next got=%h want=a5a5a5a5", rd_data[0 +: DW]);
    end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    set_rd(0, 5'd2); set_rd(1, 5'd9);
    #1;
    total++;
    if (rd_busy !== 2'b00) begin
      bad++;
      $display("FAIL sb_before busy=%b want=00", rd_busy);
    end
    step();
    idle();
    #1;
    total++;
    if (rd_busy !== 2'b10 || pend_cnt !== 6'd1) begin
      bad++;
      $display("FAIL sb_reserved busy=%b cnt=%0d want=10/1", rd_busy, pend_cnt);
    end
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = $urandom;
    #1;
    total++;
`ifdef REGFILE_BYPASS_EN
    if (rd_busy[1] !== 1'b0) begin
      bad++;
      $display("FAIL sb_write_same busy=%b want=0", rd_busy[1]);
    end
`else
    if (rd_busy[1] !== 1'b1) begin
      bad++;
      $display("FAIL sb_write_same busy=%b want=1", rd_busy[1]);
    end
`endif
    step();
    idle();
    #1;
    total++;
    if (rd_busy[1] !== 1'b0 || pend_cnt !== 6'd0 || rd_data[DW +: DW] !== mref[9]) begin
      bad++;
      $display("FAIL sb_cleared busy=%b cnt=%0d data=%h want=0/0/%h",
               rd_busy[1], pend_cnt, rd_data[DW +: DW], mref[9]);
    end
  endtask

  task automatic test_collision();
    rsv_en = 1'b1; rsv_addr = 5'd3;
    step();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    step();
    idle();
    set_rd(0, 5'd3); set_rd(1, 5'd0);
    #1;
    total++;
    if (rd_data[0 +: DW] !== 32'h55 || rd_busy[0] !== 1'b1 || pend_cnt !== 6'd1) begin
      bad++;
      $display("FAIL collision data=%h busy=%b cnt=%0d want=55/1/1",
               rd_data[0 +: DW], rd_busy[0], pend_cnt);
    end
    rsv_en = 1'b1; rsv_addr = 5'd0;
    step();
    idle();
    #1;
    total++;
    if (rd_busy[1] !== 1'b0 || pend_cnt !== 6'd1) begin
      bad++;
      $display("FAIL rsv_r0 busy=%b cnt=%0d want=0/1", rd_busy[1], pend_cnt);
    end
    // re-reserve an already pending register: count must not move
    rsv_en = 1'b1; rsv_addr = 5'd3;
    step();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = $urandom;
    rsv_en = 1'b0;
    #1;
    total++;
    if (pend_cnt !== 6'd1) begin
      bad++;
      $display("FAIL rsv_again cnt=%0d want=1", pend_cnt);
    end
    step();
    idle();
  endtask

  task automatic test_async_reset();
    for (int k = 1; k < DEPTH; k++) begin
      rsv_en = 1'b1; rsv_addr = AW'(k);
      step();
    end
    idle();
    set_rd(0, 5'd17); set_rd(1, 5'd31);
    #1;
    total++;
    if (pend_cnt !== 6'd31 || rd_busy !== 2'b11) begin
      bad++;
      $display("FAIL async_full cnt=%0d busy=%b want=31/11", pend_cnt, rd_busy);
    end
    rsv_en = 1'b1; rsv_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd17; wr_data = $urandom;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (pend_cnt !== '0 || rd_busy !== 2'b00 || rd_data !== '0) begin
      bad++;
      $display("FAIL async_drop cnt=%0d busy=%b data=%h want=0/00/0",
               pend_cnt, rd_busy, rd_data);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    total++;
    if (pend_cnt !== '0 || rd_data[0 +: DW] !== '0) begin
      bad++;
      $display("FAIL async_after cnt=%0d data=%h want=0/0", pend_cnt, rd_data[0 +: DW]);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int c = 0; c < 400; c++) begin
      wr_en    = ($urandom_range(0, 3) != 0);
      wr_addr  = AW'($urandom_range(0, 7));
      wr_data  = $urandom;
      rsv_en   = ($urandom_range(0, 2) != 0);
      rsv_addr = AW'($urandom_range(0, 7));
      for (int p = 0; p < NR; p++) begin
        set_rd(p, ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 7)));
      end
      #1;
      for (int p = 0; p < NR; p++) begin
        a = rd_addr[p*AW +: AW];
        total++;
        if (rd_data[p*DW +: DW] !== exp_rd(a) || rd_busy[p] !== exp_busy(a)) begin
          bad++;
          $display("FAIL rand_port%0d cyc=%0d addr=%0d data=%h busy=%b want=%h/%b",
                   p, c, a, rd_data[p*DW +: DW], rd_busy[p], exp_rd(a), exp_busy(a));
        end
      end
      total++;
      if (int'(pend_cnt) != exp_cnt()) begin
        bad++;
        $display("FAIL rand_cnt cyc=%0d got=%0d want=%0d", c, pend_cnt, exp_cnt());
      end
      step();
    end
    idle();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rsv_en  = 1'b0;
    rsv_addr = '0;
    model_reset();
    #1;
    test_reset();
    test_basic();
    test_bypass();
    test_scoreboard();
    test_collision();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
